// File: rtl/io_port_sender.sv
// Producer side of the CPU input handshake: a small byte FIFO feeding a
// setup / high / gap strobe sequencer that drives in_port and ready_in.
module io_port_sender #(
    parameter int unsigned BUS_WIDTH    = 8,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned SETUP_CYCLES = 2,
    parameter int unsigned HIGH_CYCLES  = 4,
    parameter int unsigned GAP_CYCLES   = 2
) (
    input  logic                          clk,
    input  logic                          n_reset,
    input  logic [BUS_WIDTH-1:0]          wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    output logic [BUS_WIDTH-1:0]          in_port,
    output logic                          ready_in,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned MaxSh  = (SETUP_CYCLES > HIGH_CYCLES) ? SETUP_CYCLES : HIGH_CYCLES;
    localparam int unsigned MaxT   = (MaxSh > GAP_CYCLES) ? MaxSh : GAP_CYCLES;
    localparam int unsigned TimerW = $clog2(MaxT + 1);

    typedef enum logic [1:0] {StIdle, StSetup, StHigh, StGap} state_e;

    state_e                state_q, state_d;
    logic [TimerW-1:0]     timer_q, timer_d;
    logic [BUS_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]       count_q, count_d;
    logic [BUS_WIDTH-1:0]  data_q;
    logic                  ready_q;
    logic                  push, pop, empty;

    // Full refuses pushes even when a pop happens the same cycle.
    assign wr_ready   = (count_q != CntW'(FIFO_DEPTH));
    assign empty      = (count_q == '0);
    assign push       = wr_valid & wr_ready;
    assign fifo_count = count_q;
    assign in_port    = data_q;
    assign ready_in   = ready_q;
    assign busy       = (state_q != StIdle) | ~empty;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = StSetup;
                    timer_d = TimerW'(SETUP_CYCLES - 1);
                end
            end
            StSetup: begin
                if (timer_q == '0) begin
                    state_d = StHigh;
                    timer_d = TimerW'(HIGH_CYCLES - 1);
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            StHigh: begin
                if (timer_q == '0) begin
                    state_d = StGap;
                    timer_d = TimerW'(GAP_CYCLES - 1);
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            StGap: begin
                if (timer_q == '0) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            count_q <= count_d;
            // ready_in is registered from the next state so it is high exactly while in StHigh.
            ready_q <= (state_d == StHigh);
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
                data_q   <= mem[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: tb/tb_io_port_sender.sv
// Directed bench for io_port_sender: scoreboard of pushed bytes checked at each
// ready_in rising edge, plus timing, flow-control, reset and CPU-echo checks.
module tb_io_port_sender;

    logic       clk = 1'b0;
    logic       n_reset;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] in_port;
    logic       ready_in;
    logic       busy;
    logic [2:0] fifo_count;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [7:0] sb[$];
    int         rise_q[$];
    logic [7:0] echo_q[$];
    logic       ri_prev = 1'b0;
    logic [7:0] mexp;

    // CPU model: two-stage input sampling, echo in_port on a synced ready_in rise.
    logic       s_rdy1, s_rdy2, s_rdy3;
    logic [7:0] s_dat1, s_dat2, out_port;

    io_port_sender dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .in_port    (in_port),
        .ready_in   (ready_in),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (n_reset && ready_in && !ri_prev) begin
            rise_q.push_back(cyc);
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $error("FAIL strobe_unexpected: observed in_port %0h, required no strobe", in_port);
            end else begin
                mexp = sb.pop_front();
                assert (in_port === mexp) else begin
                    n_err++;
                    $error("FAIL strobe_data: observed %0h required %0h", in_port, mexp);
                end
            end
        end
        ri_prev <= ready_in;
    end

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            s_rdy1   <= 1'b0;
            s_rdy2   <= 1'b0;
            s_rdy3   <= 1'b0;
            s_dat1   <= '0;
            s_dat2   <= '0;
            out_port <= '0;
        end else begin
            s_rdy1 <= ready_in;
            s_rdy2 <= s_rdy1;
            s_rdy3 <= s_rdy2;
            s_dat1 <= in_port;
            s_dat2 <= s_dat1;
            if (s_rdy2 && !s_rdy3) begin
                out_port <= s_dat2;
                echo_q.push_back(s_dat2);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] d);
        int t = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        while (!wr_ready && t < 100) begin
            tick();
            t++;
        end
        if (t >= 100) check("push_timeout", {31'b0, wr_ready}, 32'd1);
        tick();
        sb.push_back(d);
        wr_valid = 1'b0;
        wr_data  = 'x;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || sb.size() != 0) && t < 300) begin
            tick();
            t++;
        end
        tick();
        tick();
        tick();
        check("idle_busy", {31'b0, busy}, 32'd0);
        check("idle_sb_empty", sb.size(), 32'd0);
    endtask

    initial begin
        int t;
        int c0;
        n_reset  = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;

        // 1: reset state
        tick();
        tick();
        check("rst_in_port", in_port, 32'h0);
        check("rst_ready_in", {31'b0, ready_in}, 32'd0);
        check("rst_wr_ready", {31'b0, wr_ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_fifo_count", fifo_count, 32'd0);
        n_reset = 1'b1;
        tick();

        // 2: single byte timing
        rise_q.delete();
        push_byte(8'hA5);
        check("single_count", fifo_count, 32'd1);
        check("single_busy", {31'b0, busy}, 32'd1);
        tick();
        check("single_in_port_e1", in_port, 32'hA5);
        check("single_ready_e1", {31'b0, ready_in}, 32'd0);
        tick();
        check("single_ready_e2", {31'b0, ready_in}, 32'd0);
        for (int k = 3; k <= 6; k++) begin
            tick();
            check("single_ready_high", {31'b0, ready_in}, 32'd1);
        end
        for (int k = 7; k <= 8; k++) begin
            tick();
            check("single_ready_gap", {31'b0, ready_in}, 32'd0);
            check("single_busy_gap", {31'b0, busy}, 32'd1);
        end
        tick();
        check("single_busy_done", {31'b0, busy}, 32'd0);
        check("single_in_port_hold", in_port, 32'hA5);
        check("single_rises", rise_q.size(), 32'd1);

        // 3 + 4: burst, full FIFO and refused push during a pop
        rise_q.delete();
        for (int b = 1; b <= 5; b++) push_byte(8'(b));
        check("burst_full_count", fifo_count, 32'd4);
        check("burst_full_wr_ready", {31'b0, wr_ready}, 32'd0);
        wr_valid = 1'b1;
        wr_data  = 8'h06;
        t = 0;
        while (!wr_ready && t < 50) begin
            check("full_hold_count", fifo_count, 32'd4);
            tick();
            t++;
        end
        check("full_refused_count", fifo_count, 32'd3);
        check("full_wr_ready_back", {31'b0, wr_ready}, 32'd1);
        tick();
        sb.push_back(8'h06);
        wr_valid = 1'b0;
        wr_data  = 'x;
        check("full_accept_count", fifo_count, 32'd4);
        wait_idle();
        check("burst_rises", rise_q.size(), 32'd6);
        for (int i = 1; i < rise_q.size(); i++)
            check("burst_period", rise_q[i] - rise_q[i-1], 32'd9);
        check("burst_in_port_last", in_port, 32'h06);

        // 5: reset during the high phase
        push_byte(8'h77);
        push_byte(8'h88);
        t = 0;
        while (!ready_in && t < 50) begin
            tick();
            t++;
        end
        check("mid_ready_seen", {31'b0, ready_in}, 32'd1);
        #2;
        n_reset = 1'b0;
        #1;
        check("mid_ready_drop", {31'b0, ready_in}, 32'd0);
        check("mid_count", fifo_count, 32'd0);
        check("mid_busy", {31'b0, busy}, 32'd0);
        check("mid_in_port", in_port, 32'h0);
        check("mid_wr_ready", {31'b0, wr_ready}, 32'd1);
        sb.delete();
        tick();
        tick();
        n_reset = 1'b1;
        tick();
        rise_q.delete();
        push_byte(8'h3C);
        c0 = cyc;
        wait_idle();
        check("post_rst_rises", rise_q.size(), 32'd1);
        if (rise_q.size() == 1) check("post_rst_latency", rise_q[0] - c0, 32'd3);
        check("post_rst_in_port", in_port, 32'h3C);

        // 6: CPU echo through two-stage sampling
        echo_q.delete();
        push_byte(8'h12);
        push_byte(8'h34);
        wait_idle();
        check("cpu_echo_count", echo_q.size(), 32'd2);
        if (echo_q.size() == 2) begin
            check("cpu_echo_0", echo_q[0], 32'h12);
            check("cpu_echo_1", echo_q[1], 32'h34);
        end
        check("cpu_out_port", out_port, 32'h34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
